// File: rtl/mic_capture.sv
// Serial-ADC frame capture for the FFT front end: paces ADCS7476-style conversions
// off a free-running sample tick and fills a 2^N_LOG2-deep sample RAM.
// Optional build macro MIC_CAPTURE_SIGNED_EN stores samples as two's complement.
module mic_capture #(
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 2268,
  parameter int N_LOG2     = 8,
  parameter int DATA_W     = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Arm,
  input  logic              Frame_ack,
  input  logic [N_LOG2-1:0] Rd_addr,
  output logic [DATA_W-1:0] Rd_data,
  output logic              Busy,
  output logic              Frame_ready,
  output logic              Adc_cs_n,
  output logic              Adc_sclk,
  input  logic              Adc_sdata
);

  localparam int TW    = $clog2(SAMPLE_DIV);
  localparam int DW    = $clog2(SCLK_DIV);
  localparam int DEPTH = 1 << N_LOG2;
  localparam logic [TW-1:0]     TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0]     DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [4:0]        LEAD      = 5'(16 - DATA_W);
  localparam logic [N_LOG2-1:0] IDX_LAST  = '1;

  typedef enum logic [2:0] {IDLE, WAIT_TICK, CONVERT, STORE, DONE} state_t;

  state_t              state;
  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [DW-1:0]       div_cnt;
  logic [4:0]          edge_cnt;
  logic [N_LOG2-1:0]   idx;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   sample;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Free-running so sample spacing is independent of when Arm arrives.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else                       tick_cnt <= tick_cnt + 1'b1;
  end
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= IDLE;
      Busy        <= 1'b0;
      Frame_ready <= 1'b0;
      Adc_cs_n    <= 1'b1;
      Adc_sclk    <= 1'b1;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      idx         <= '0;
      shreg       <= '0;
    end else begin
      case (state)
        IDLE: if (Arm) begin
          state <= WAIT_TICK;
          Busy  <= 1'b1;
          idx   <= '0;
        end
        WAIT_TICK: if (tick) begin
          state    <= CONVERT;
          Adc_cs_n <= 1'b0;
          Adc_sclk <= 1'b0;
          div_cnt  <= '0;
          edge_cnt <= '0;
        end
        CONVERT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            Adc_sclk <= ~Adc_sclk;
            if (!Adc_sclk) begin
              // Rising SCLK: leading zeros are counted but not shifted in.
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt >= LEAD) shreg <= {shreg[DATA_W-2:0], Adc_sdata};
            end else if (edge_cnt == 5'd16) begin
              Adc_cs_n <= 1'b1;
              Adc_sclk <= 1'b1;
              state    <= STORE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        STORE: begin
          if (idx == IDX_LAST) begin
            state       <= DONE;
            Busy        <= 1'b0;
            Frame_ready <= 1'b1;
          end else begin
            idx   <= idx + 1'b1;
            state <= WAIT_TICK;
          end
        end
        DONE: begin
          if (Arm) begin
            state       <= WAIT_TICK;
            Frame_ready <= 1'b0;
            Busy        <= 1'b1;
            idx         <= '0;
          end else if (Frame_ack) begin
            state       <= IDLE;
            Frame_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIC_CAPTURE_SIGNED_EN
  assign sample = shreg ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign sample = shreg;
`endif

  // RAM has no reset so it maps to block RAM; read-before-write on collisions.
  always_ff @(posedge Clk) begin
    if (state == STORE) mem[idx] <= sample;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) Rd_data <= '0;
    else        Rd_data <= mem[Rd_addr];
  end

endmodule
